uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_tx.sv | 91 +++++++++
 tb/tb_uart_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default bit-timing width.
package uart_pkg;

  localparam int UART_BIT_LENGTH_WIDTH = 16;

  // Frame states, one per bit slot on the line.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    BIT0  = 4'd2,
    BIT1  = 4'd3,
    BIT2  = 4'd4,
    BIT3  = 4'd5,
    BIT4  = 4'd6,
    BIT5  = 4'd7,
    BIT6  = 4'd8,
    BIT7  = 4'd9,
    STOP  = 4'd10
  } uart_state_t;

  // Data-bit slots, where the line carries the shift register LSB.
  function automatic logic is_data_state(input uart_state_t s);
    return (s >= BIT0) && (s <= BIT7);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers/count and a fall-through head.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH_LOG2-1:0]       wr_ptr;
  logic [DEPTH_LOG2-1:0]       rd_ptr;
  logic                        wr_ok;
  logic                        rd_ok;

  // A write while full is dropped even if a pop happens on the same edge.
  always_comb begin
    full    = (count == DEPTH_CNT);
    empty   = (count == '0);
    wr_ok   = wr_en && !full;
    rd_ok   = rd_en && !empty;
    rd_data = mem[rd_ptr];
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; emptiness is governed by the count.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames from a byte FIFO, programmable bit time.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_LENGTH_WIDTH = UART_BIT_LENGTH_WIDTH,
  parameter int FIFO_DEPTH_LOG2  = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [7:0]                  data,
  input  logic                        write_enable,
  input  logic [BIT_LENGTH_WIDTH-1:0] bit_length,
  output logic                        txd,
  output logic                        full,
  output logic                        busy
);

  uart_state_t                 state;
  logic [BIT_LENGTH_WIDTH-1:0] bit_cnt;
  logic [BIT_LENGTH_WIDTH-1:0] bit_len_q;
  logic [7:0]                  shreg;
  logic [7:0]                  fifo_head;
  logic                        fifo_empty;
  logic [FIFO_DEPTH_LOG2:0]    fifo_count;
  logic                        bit_end;
  logic                        pop;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (write_enable),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Pop when a new frame can start: from idle, or straight out of a stop bit.
  always_comb begin
    bit_end = (bit_cnt == bit_len_q);
    pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    busy    = (state != IDLE) || (fifo_count != '0);
  end

  // Frame sequencer; txd is registered from the current state, so the line
  // trails the state by one clock uniformly across the whole frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_len_q <= '0;
      shreg     <= '0;
      txd       <= 1'b1;
    end else begin
      case (state)
        IDLE:    txd <= 1'b1;
        START:   txd <= 1'b0;
        STOP:    txd <= 1'b1;
        default: txd <= is_data_state(state) ? shreg[0] : 1'b1;
      endcase

      if (pop) begin
        state     <= START;
        shreg     <= fifo_head;
        bit_len_q <= bit_length;
        bit_cnt   <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          bit_cnt <= '0;
          case (state)
            START:   state <= BIT0;
            BIT7:    state <= STOP;
            STOP:    state <= IDLE;
            default: begin
              state <= uart_state_t'(state + 4'd1);
              shreg <= shreg >> 1;
            end
          endcase
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench: stimulus queues expected frames, a line monitor decodes txd.
module tb_uart_tx;

  logic        clock;
  logic        reset_n;
  logic [7:0]  data;
  logic        write_enable;
  logic [15:0] bit_length;
  logic        txd;
  logic        full;
  logic        busy;

  typedef struct {
    logic [7:0] b;
    int         bl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // monitor state
  bit   mon_active = 0;
  bit   just_ended = 0;
  int   mon_bit, mon_cnt;
  bit   bit_ok;
  logic mon_seen, mon_want;
  exp_t cur;
  int   b2b_cnt = 0;
  int   frames_rx = 0;

  uart_tx dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .data         (data),
    .write_enable (write_enable),
    .bit_length   (bit_length),
    .txd          (txd),
    .full         (full),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Line monitor: a frame is start(0), 8 data bits LSB first, stop(1),
  // each held bl+1 clocks, where bl is the rate in effect when queued.
  always @(negedge clock) begin
    if (!reset_n) begin
      mon_active = 0;
      just_ended = 0;
    end else begin
      if (!mon_active) begin
        if (txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got start bit, expected idle line");
          end else begin
            cur        = exp_q.pop_front();
            mon_active = 1;
            mon_bit    = 0;
            mon_cnt    = 0;
            bit_ok     = 1;
            if (just_ended) b2b_cnt++;
          end
        end
        just_ended = 0;
      end
      if (mon_active) begin
        if (mon_bit == 0)      mon_want = 1'b0;
        else if (mon_bit == 9) mon_want = 1'b1;
        else                   mon_want = cur.b[mon_bit-1];
        if (txd !== mon_want) begin
          bit_ok   = 0;
          mon_seen = txd;
        end
        mon_cnt++;
        if (mon_cnt == cur.bl + 1) begin
          total++;
          if (!bit_ok) begin
            bad++;
            $display("FAIL frame_%02h_bit%0d: got %b expected %b", cur.b, mon_bit, mon_seen, mon_want);
          end
          mon_bit++;
          mon_cnt = 0;
          bit_ok  = 1;
          if (mon_bit == 10) begin
            mon_active = 0;
            just_ended = 1;
            frames_rx++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    exp_t e;
    data         = b;
    write_enable = 1'b1;
    if (accept) begin
      e.b  = b;
      e.bl = int'(bit_length);
      exp_q.push_back(e);
    end
    tick(1);
    write_enable = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick(1);
      if (busy === 1'b0 && !mon_active) done = 1;
    end
    if (!done) chk("idle_timeout", 32'(busy), 32'h0);
    tick(2);
  endtask

  task automatic wait_txd_low(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (txd === 1'b0) done = 1;
      else tick(1);
    end
    if (!done) chk("start_timeout", 32'(txd), 32'h0);
  endtask

  // Single frame from idle: pop one edge after the write, line low the next,
  // busy drops when the 10-bit-time frame sequence completes.
  task automatic single_frame(input logic [7:0] b, input int bl);
    int flen = 10 * (bl + 1);
    bit_length = 16'(bl);
    wr(b, 1);
    for (int k = 1; k <= flen + 1; k++) begin
      tick(1);
      if (k == 1)        chk($sformatf("txd_pop_edge_bl%0d", bl), 32'(txd), 32'h1);
      if (k == 2)        chk($sformatf("txd_start_edge_bl%0d", bl), 32'(txd), 32'h0);
      if (k == flen)     chk($sformatf("busy_last_edge_bl%0d", bl), 32'(busy), 32'h1);
      if (k == flen + 1) chk($sformatf("busy_drop_edge_bl%0d", bl), 32'(busy), 32'h0);
    end
    wait_idle(200);
  endtask

  initial begin
    int b0, f0, sent, n;
    bit quiet;
    reset_n      = 1'b1;
    data         = 8'h00;
    write_enable = 1'b0;
    bit_length   = 16'd3;
    #1 reset_n   = 1'b0;
    tick(3);
    chk("reset_txd", 32'(txd), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_full", 32'(full), 32'h0);

    // release and write on the very first edge after release
    reset_n = 1'b1;
    single_frame(8'hA5, 3);

    // burst of three bytes on consecutive clocks -> contiguous frames
    b0 = b2b_cnt;
    wr(8'h00, 1);
    wr(8'hFF, 1);
    wr(8'h55, 1);
    wait_idle(500);
    chk("burst_back_to_back", 32'(b2b_cnt - b0), 32'd2);

    // overflow: one frame in flight, then 17 writes; the 17th is dropped
    wr(8'hEE, 1);
    wait_txd_low(20);
    b0 = b2b_cnt;
    f0 = frames_rx;
    for (int i = 1; i <= 17; i++) begin
      wr(8'(i), i <= 16);
      if (i == 15) chk("full_at_15", 32'(full), 32'h0);
      if (i == 16) chk("full_at_16", 32'(full), 32'h1);
      if (i == 17) chk("full_after_drop", 32'(full), 32'h1);
    end
    wait_idle(2000);
    chk("overflow_frames", 32'(frames_rx - f0), 32'd17);
    chk("overflow_back_to_back", 32'(b2b_cnt - b0), 32'd16);

    // rate change mid-frame: current frame keeps old rate
    bit_length = 16'd3;
    wr(8'h3C, 1);
    tick(6);
    bit_length = 16'd7;
    wr(8'hC3, 1);
    wait_idle(500);

    // reset during BIT3 with 5 bytes queued
    bit_length = 16'd3;
    for (int i = 0; i < 6; i++) wr(8'(8'h90 + i), 1);
    tick(14);
    chk("busy_before_reset", 32'(busy), 32'h1);
    #1 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_txd", 32'(txd), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_full", 32'(full), 32'h0);
    tick(3);
    reset_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (txd !== 1'b1 || busy !== 1'b0) quiet = 0;
    end
    chk("quiet_after_reset", 32'(quiet), 32'h1);

    // minimum bit time: one clock per bit
    single_frame(8'h96, 0);

    // randomized loopback: bursts of up to 16 bytes at random rates
    sent = 0;
    while (sent < 256) begin
      bit_length = 16'($urandom_range(0, 3));
      n = $urandom_range(1, 16);
      if (n > 256 - sent) n = 256 - sent;
      for (int i = 0; i < n; i++) begin
        wr(8'($urandom_range(0, 255)), 1);
        tick($urandom_range(0, 2));
      end
      sent += n;
      wait_idle(2000);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("monitor_idle", 32'(mon_active), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
